sum_bcd_display_scanner: RTL and testbench
==========================================

# sum_bcd_display_scanner

- Downstream display stage for the operand adder.
- Accepts an 8-bit binary result over a valid/ready handshake and converts it to three BCD digits with a sequential double-dabble engine (one shift per cycle).
- Drives a 3-digit common-cathode 7-segment display by time-multiplexing digits, with optional leading-zero blanking.
- Replaces the single-digit "error above 9" display path, so sums up to 255 are shown in full.

## Interface

Parameters:
- SCAN_DIV, 1024: clock cycles each digit stays enabled. Legal range ≥ 1.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 shows all three digits.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- bin_in  in  8  unsigned binary value to display.
- bin_valid  in  1  bin_in is valid.
- bin_ready  out  1  block can accept a value; high only in IDLE.
- busy  out  1  conversion in progress; equals ~bin_ready.
- seg  out  8  segment drive, active high. Bit0 = a … bit6 = g; bit7 = dp, always 0.
- dig_en  out  3  one-hot digit enable, active high. Bit0 = ones, bit1 = tens, bit2 = hundreds.

## Operation

FSM states: IDLE, CONV.

IDLE:
- bin_ready = 1.
- On bin_valid & bin_ready: load shift register with bin_in, clear BCD scratch (12 bits), clear iteration counter, go to CONV.

CONV (exactly 8 cycles):
- Each cycle, every BCD nibble ≥ 5 gets +3 (all three nibbles in parallel).
- Then shift {bcd, bin} left by 1 and increment the counter.
- On the 8th shift edge: load the result into the display digit registers (hund, tens, ones) and go to IDLE.
- bin_valid is ignored throughout CONV. Values presented while busy are dropped, not queued.

Digit registers:
- Hold the last completed conversion.
- Unchanged during CONV; the display keeps showing the old value until the 8th-shift edge.

Scanner:
- Prescaler counts 0..SCAN_DIV-1.
- On wrap, the digit index advances ones → tens → hundreds → ones.
- The scanner runs continuously and independently of the FSM. A digit-register update never resets the index or the prescaler.

Segment decode (of the selected digit):
- 0=0x3f, 1=0x06, 2=0x5b, 3=0x4f, 4=0x66, 5=0x6d, 6=0x7d, 7=0x07, 8=0x7f, 9=0x6f.
- Nibbles > 9 cannot occur; if reached, decode to 0x00.

Blanking (BLANK_LZ=1):
- Hundreds slot: seg = 0x00 when hund == 0.
- Tens slot: seg = 0x00 when hund == 0 and tens == 0.
- Ones slot: never blanked.
- dig_en still cycles through blanked slots.

seg and dig_en are combinational decodes of registered state (index, digit registers); no extra output register.

Reset (async, rst_n low), effective immediately:
- FSM → IDLE; digits, prescaler, index and scratch cleared.
- Resulting outputs: bin_ready=1, busy=0, dig_en=3'b001, seg=0x3f. With BLANK_LZ=0 all slots show 0x3f.
- Reset mid-conversion aborts the conversion; no partial result is ever loaded.

## Timing

- Accept edge = edge where bin_valid & bin_ready is sampled high (call it edge 0).
- bin_ready is low for cycles 1–8 and high again from cycle 9.
- Digit registers update on edge 8. Back-to-back throughput: one value per 9 cycles.
- Simultaneous events:
  - bin_valid high on the completing edge 8 is not accepted; ready is still low that cycle.
  - A prescaler wrap on edge 8 advances the index, and the new slot shows the new digits.
- Scan period = 3·SCAN_DIV cycles.
- SCAN_DIV=1 advances the digit index every cycle.

## Test plan

- **Reset:** hold rst_n low mid-run, then release → immediately dig_en=001, seg=0x3f, bin_ready=1, busy=0; after release the prescaler starts from 0.
- **Value 255, SCAN_DIV=4:** accept at edge 0 → busy high for exactly 8 cycles, digits 2/5/5 loaded at edge 8. Over the scan: dig_en cycles 001→010→100 every 4 cycles; seg=0x6d, 0x6d, 0x5b.
- **Blanking:**
  - BLANK_LZ=1, value 7 → seg 0x07 on ones, 0x00 on tens and hundreds.
  - BLANK_LZ=1, value 100 → 0x3f, 0x3f, 0x06.
  - BLANK_LZ=0, value 7 → 0x07, 0x3f, 0x3f.
- **Backpressure:** bin_valid held high with bin_in changing 12→34→56 each cycle → only 12 accepted; the next accept is at cycle 9, taking the bin_in present then.
- **Async reset at cycle 4 of converting 200:** outputs go to reset values without a clock edge; after release the display shows 0, never 200 or a partial value.
- **Exhaustive sweep 0..255, SCAN_DIV=1:** every value checked against a golden div/mod-10 model on all three slots, including blanking rules.

Source files
------------

// File: rtl/sum_bcd_display_scanner.sv
// Binary-to-BCD display stage: sequential double-dabble conversion of an 8-bit value,
// then time-multiplexed drive of a 3-digit common-cathode 7-segment display.
//
// state | meaning
// IDLE  | ready for a new value, display shows last completed conversion
// CONV  | eight add-3/shift steps in progress, bin_valid ignored
module sum_bcd_display_scanner #(
  parameter int SCAN_DIV = 1024,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bin_in,
  input  logic       bin_valid,
  output logic       bin_ready,
  output logic       busy,
  output logic [7:0] seg,
  output logic [2:0] dig_en
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state;
  logic [7:0]    bin_sr;
  logic [11:0]   bcd;
  logic [2:0]    iter;
  logic [3:0]    hund, tens, ones;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [11:0]   bcd_adj;
  logic [19:0]   shifted;
  logic [3:0]    sel;
  logic          blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  assign shifted = {bcd_adj, bin_sr} << 1;
  assign busy    = ~bin_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_ready <= 1'b1;
      bin_sr    <= '0;
      bcd       <= '0;
      iter      <= '0;
      hund      <= '0;
      tens      <= '0;
      ones      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bin_valid) begin
            bin_sr    <= bin_in;
            bcd       <= '0;
            iter      <= '0;
            bin_ready <= 1'b0;
            state     <= CONV;
          end
        end
        CONV: begin
          bcd    <= shifted[19:8];
          bin_sr <= shifted[7:0];
          iter   <= iter + 3'd1;
          // Digits change only on the final shift, so no partial result is ever shown.
          if (iter == 3'd7) begin
            hund      <= shifted[19:16];
            tens      <= shifted[15:12];
            ones      <= shifted[11:8];
            bin_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          bin_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    sel    = ones;
    blank  = 1'b0;
    dig_en = 3'b001;
    case (idx)
      2'd1: begin
        sel    = tens;
        blank  = BLANK_LZ && (hund == 4'd0) && (tens == 4'd0);
        dig_en = 3'b010;
      end
      2'd2: begin
        sel    = hund;
        blank  = BLANK_LZ && (hund == 4'd0);
        dig_en = 3'b100;
      end
      default: begin
        sel    = ones;
        blank  = 1'b0;
        dig_en = 3'b001;
      end
    endcase
  end

  always_comb begin
    seg = 8'h00;
    case (sel)
      4'd0: seg = 8'h3f;
      4'd1: seg = 8'h06;
      4'd2: seg = 8'h5b;
      4'd3: seg = 8'h4f;
      4'd4: seg = 8'h66;
      4'd5: seg = 8'h6d;
      4'd6: seg = 8'h7d;
      4'd7: seg = 8'h07;
      4'd8: seg = 8'h7f;
      4'd9: seg = 8'h6f;
      default: seg = 8'h00;
    endcase
    if (blank) seg = 8'h00;
  end

endmodule

// File: tb/tb_sum_bcd_display_scanner.sv
// Bench for sum_bcd_display_scanner: three instances (SCAN_DIV/BLANK_LZ variants) share stimulus
// and are checked every cycle against a div/mod-10 display model plus literal expectations.
module tb_sum_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bin_in = 8'd0;
  logic       bin_valid = 1'b0;

  logic       a_ready, a_busy, b_ready, b_busy, c_ready, c_busy;
  logic [7:0] a_seg, b_seg, c_seg;
  logic [2:0] a_en, b_en, c_en;

  int total = 0;
  int bad = 0;

  localparam logic [7:0] SEG7 [10] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66,
                                       8'h6d, 8'h7d, 8'h07, 8'h7f, 8'h6f};

  always #5 clk = ~clk;

  sum_bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_valid(bin_valid),
    .bin_ready(a_ready), .busy(a_busy), .seg(a_seg), .dig_en(a_en));

  sum_bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_valid(bin_valid),
    .bin_ready(b_ready), .busy(b_busy), .seg(b_seg), .dig_en(b_en));

  sum_bcd_display_scanner #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_valid(bin_valid),
    .bin_ready(c_ready), .busy(c_busy), .seg(c_seg), .dig_en(c_en));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected segments for a displayed value: slot 0=ones, 1=tens, 2=hundreds.
  function automatic logic [7:0] exp_seg(input int v, input int slot, input bit blz);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    if (slot == 0) return SEG7[o];
    if (slot == 1) return (blz && h == 0 && t == 0) ? 8'h00 : SEG7[t];
    return (blz && h == 0) ? 8'h00 : SEG7[h];
  endfunction

  // Model: cycles left in conversion, value on display, edges since reset release.
  int m_left = 0;
  int m_val  = 0;
  int m_pend = 0;
  int m_tick = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_val  = 0;
      m_tick = 0;
    end else begin
      m_tick++;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_val = m_pend;
      end else if (bin_valid) begin
        m_pend = bin_in;
        m_left = 8;
      end
    end
  end

  always @(negedge clk) begin
    int ia, ic;
    ia = (m_tick / 4) % 3;
    ic = m_tick % 3;
    chk("a_ready", a_ready, m_left == 0);
    chk("a_busy",  a_busy,  m_left != 0);
    chk("b_ready", b_ready, m_left == 0);
    chk("c_busy",  c_busy,  m_left != 0);
    chk("a_dig_en", a_en, 3'b001 << ia);
    chk("a_seg", a_seg, exp_seg(m_val, ia, 1'b1));
    chk("b_dig_en", b_en, 3'b001 << ia);
    chk("b_seg", b_seg, exp_seg(m_val, ia, 1'b0));
    chk("c_dig_en", c_en, 3'b001 << ic);
    chk("c_seg", c_seg, exp_seg(m_val, ic, 1'b1));
  end

  function automatic logic [2:0] get_en(input int which);
    return (which == 0) ? a_en : b_en;
  endfunction

  function automatic logic [7:0] get_seg(input int which);
    return (which == 0) ? a_seg : b_seg;
  endfunction

  // Wait (bounded) until instance a (0) or b (1) enables the given slot, then check its segments.
  task automatic slot_is(input string name, input int which, input int slot, input logic [7:0] exp);
    int n;
    logic [2:0] en;
    en = 3'b001 << slot;
    n = 0;
    while (get_en(which) != en && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_en"}, get_en(which), en);
    chk(name, get_seg(which), exp);
  endtask

  task automatic send(input logic [7:0] v);
    @(negedge clk);
    bin_in = v;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  int seq[10] = '{12, 34, 56, 78, 90, 11, 22, 33, 44, 99};

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_seg", a_seg, 8'h3f);
    chk("rst_en", a_en, 3'b001);
    rst_n = 1'b1;

    // 255 with SCAN_DIV=4: busy exactly 8 cycles, then 5/5/2.
    @(negedge clk);
    bin_in = 8'd255;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    n = 0;
    while (a_busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 8);
    slot_is("v255_ones", 0, 0, 8'h6d);
    repeat (4) @(negedge clk);
    chk("v255_tens_en", a_en, 3'b010);
    chk("v255_tens", a_seg, 8'h6d);
    repeat (4) @(negedge clk);
    chk("v255_hund_en", a_en, 3'b100);
    chk("v255_hund", a_seg, 8'h5b);

    // Blanking.
    send(8'd7);
    slot_is("v7_ones_lz", 0, 0, 8'h07);
    slot_is("v7_tens_lz", 0, 1, 8'h00);
    slot_is("v7_hund_lz", 0, 2, 8'h00);
    slot_is("v7_ones", 1, 0, 8'h07);
    slot_is("v7_tens", 1, 1, 8'h3f);
    slot_is("v7_hund", 1, 2, 8'h3f);
    send(8'd100);
    slot_is("v100_ones", 0, 0, 8'h3f);
    slot_is("v100_tens", 0, 1, 8'h3f);
    slot_is("v100_hund", 0, 2, 8'h06);

    // Backpressure: valid held, value changes every cycle; accepts at edges 0 and 9.
    @(negedge clk);
    bin_valid = 1'b1;
    bin_in = 8'(seq[0]);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (k == 9) chk("bp_ready_c9", a_ready, 1'b1);
      bin_in = 8'(seq[k]);
    end
    @(negedge clk);
    chk("bp_accept_c9", a_busy, 1'b1);
    bin_valid = 1'b0;
    repeat (10) @(negedge clk);
    slot_is("bp99_ones", 1, 0, 8'h6f);
    slot_is("bp99_tens", 1, 1, 8'h6f);
    slot_is("bp99_hund", 1, 2, 8'h3f);

    // Async reset at cycle 4 of converting 200.
    @(negedge clk);
    bin_in = 8'd200;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", a_ready, 1'b1);
    chk("arst_busy", a_busy, 1'b0);
    chk("arst_en", a_en, 3'b001);
    chk("arst_seg", a_seg, 8'h3f);
    chk("arst_seg_b", b_seg, 8'h3f);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    slot_is("arst_hund_b", 1, 2, 8'h3f);
    slot_is("arst_ones_b", 1, 0, 8'h3f);

    // Exhaustive sweep; per-cycle model checks cover every slot of the SCAN_DIV=1 instance.
    for (int v = 0; v < 256; v++) begin
      send(8'(v));
      repeat (3) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
